// File: rtl/cmsdk_ahb_bm_pkg.sv
// Encodings shared by the bus-matrix input stage, output arbiter and output stage.
package cmsdk_ahb_bm_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only NONSEQ/SEQ carry a real transfer; IDLE and BUSY are never held.
    function automatic logic trans_is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/cmsdk_ahb_bm_input_stage_if.sv
// Master-side AHB-Lite bus of one bus-matrix input port.
// Handshake: an address phase is offered when HSELS & HTRANSS[1] and is taken
// when HREADYS is high; HREADYOUTS low stretches the master's current phase.
interface cmsdk_ahb_bm_input_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS,
        output HREADYOUTS, HRESPS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS,
        input  HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/cmsdk_ahb_bm_input_stage.sv
// Bus-matrix input stage: holds an address phase the matrix cannot take yet and
// stalls the master until it is granted, then relays the slave's data-phase response.
module cmsdk_ahb_bm_input_stage
    import cmsdk_ahb_bm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    cmsdk_ahb_bm_input_stage_if.slave ahb,
    output logic                  sel_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [1:0]            trans_in,
    output logic                  write_in,
    output logic [2:0]            size_in,
    output logic [2:0]            burst_in,
    output logic [3:0]            prot_in,
    output logic                  mastlock_in,
    output logic                  held_tran_in,
    input  logic                  active_in,
    input  logic                  readyout_in,
    input  logic                  resp_in
);

    logic                  w_trans_valid;
    logic                  r_hold;
    logic                  r_data_ph;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_trans;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [2:0]            r_burst;
    logic [3:0]            r_prot;
    logic                  r_mastlock;

    assign w_trans_valid = ahb.HSELS & trans_is_active(ahb.HTRANSS) & ahb.HREADYS;

    // A new capture is refused while holding; a master that still offers one is out of protocol.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_hold     <= 1'b0;
            r_addr     <= '0;
            r_trans    <= '0;
            r_write    <= 1'b0;
            r_size     <= '0;
            r_burst    <= '0;
            r_prot     <= '0;
            r_mastlock <= 1'b0;
        end else if (w_trans_valid && !active_in && !r_hold) begin
            r_hold     <= 1'b1;
            r_addr     <= ahb.HADDRS;
            r_trans    <= ahb.HTRANSS;
            r_write    <= ahb.HWRITES;
            r_size     <= ahb.HSIZES;
            r_burst    <= ahb.HBURSTS;
            r_prot     <= ahb.HPROTS;
            r_mastlock <= ahb.HMASTLOCKS;
        end else if (r_hold && active_in) begin
            r_hold     <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_data_ph <= 1'b0;
        end else if (active_in) begin
            r_data_ph <= 1'b1;
        end else if (readyout_in) begin
            r_data_ph <= 1'b0;
        end
    end

    always_comb begin
        sel_in       = r_hold | (ahb.HSELS & ahb.HREADYS);
        held_tran_in = r_hold;
        addr_in      = ahb.HADDRS;
        trans_in     = ahb.HTRANSS;
        write_in     = ahb.HWRITES;
        size_in      = ahb.HSIZES;
        burst_in     = ahb.HBURSTS;
        prot_in      = ahb.HPROTS;
        mastlock_in  = ahb.HMASTLOCKS;
        if (r_hold) begin
            addr_in     = r_addr;
            trans_in    = r_trans;
            write_in    = r_write;
            size_in     = r_size;
            burst_in    = r_burst;
            prot_in     = r_prot;
            mastlock_in = r_mastlock;
        end
    end

    // Response path: forced wait while holding, otherwise the owning slave's handshake.
    always_comb begin
        ahb.HREADYOUTS = 1'b1;
        ahb.HRESPS     = HRESP_OKAY;
        if (r_hold) begin
            ahb.HREADYOUTS = 1'b0;
        end else if (r_data_ph) begin
            ahb.HREADYOUTS = readyout_in;
            ahb.HRESPS     = resp_in;
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_bm_input_stage.sv
// Directed and randomised scenarios for the bus-matrix input stage; expected
// presented/response values are queued per cycle and compared mid-low-phase.
module tb_cmsdk_ahb_bm_input_stage;
    import cmsdk_ahb_bm_pkg::*;

    localparam int W = 50;

    logic        HCLK;
    logic        HRESETn;
    logic        sel_in;
    logic [31:0] addr_in;
    logic [1:0]  trans_in;
    logic        write_in;
    logic [2:0]  size_in;
    logic [2:0]  burst_in;
    logic [3:0]  prot_in;
    logic        mastlock_in;
    logic        held_tran_in;
    logic        active_in;
    logic        readyout_in;
    logic        resp_in;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_total;
    int           n_bad;

    cmsdk_ahb_bm_input_stage_if #(.ADDR_WIDTH(32)) bus ();

    cmsdk_ahb_bm_input_stage #(.ADDR_WIDTH(32)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .ahb          (bus),
        .sel_in       (sel_in),
        .addr_in      (addr_in),
        .trans_in     (trans_in),
        .write_in     (write_in),
        .size_in      (size_in),
        .burst_in     (burst_in),
        .prot_in      (prot_in),
        .mastlock_in  (mastlock_in),
        .held_tran_in (held_tran_in),
        .active_in    (active_in),
        .readyout_in  (readyout_in),
        .resp_in      (resp_in)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Side fields are derived from the address so a stale held copy is visible.
    function automatic logic [8:0] attr(input logic [31:0] addr);
        return addr[31:23] ^ addr[8:0];
    endfunction

    function automatic logic [W-1:0] pack_exp(input logic sel, input logic held,
                                              input logic rdy, input logic rsp,
                                              input logic [1:0] trans,
                                              input logic [31:0] addr,
                                              input logic [2:0] burst);
        logic [8:0] a;
        a = attr(addr);
        return {sel, held, rdy, rsp, trans, a[0], a[3:1], burst, a[7:4], a[8], addr};
    endfunction

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic rstn,
                        input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic [2:0] burst,
                        input logic hrdy, input logic act,
                        input logic rin, input logic rsp,
                        input logic [W-1:0] exp);
        logic [8:0] a;
        @(negedge HCLK);
        a              = attr(addr);
        HRESETn        = rstn;
        bus.HSELS      = sel;
        bus.HTRANSS    = trans;
        bus.HADDRS     = addr;
        bus.HBURSTS    = burst;
        bus.HWRITES    = a[0];
        bus.HSIZES     = a[3:1];
        bus.HPROTS     = a[7:4];
        bus.HMASTLOCKS = a[8];
        bus.HREADYS    = hrdy;
        active_in      = act;
        readyout_in    = rin;
        resp_in        = rsp;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    always begin
        @(negedge HCLK);
        #2;
        if (exp_q.size() != 0) begin
            check_eq(tag_q.pop_front(),
                     {sel_in, held_tran_in, bus.HREADYOUTS, bus.HRESPS, trans_in, write_in,
                      size_in, burst_in, prot_in, mastlock_in, addr_in},
                     exp_q.pop_front());
        end
    end

    initial begin
        logic        r_sel;
        logic [1:0]  r_tr;
        logic [31:0] r_ad;
        logic [2:0]  r_bu;
        n_total        = 0;
        n_bad          = 0;
        HRESETn        = 1'b0;
        bus.HSELS      = 1'b0;
        bus.HTRANSS    = HTRANS_IDLE;
        bus.HADDRS     = '0;
        bus.HBURSTS    = HBURST_SINGLE;
        bus.HWRITES    = 1'b0;
        bus.HSIZES     = '0;
        bus.HPROTS     = '0;
        bus.HMASTLOCKS = 1'b0;
        bus.HREADYS    = 1'b1;
        active_in      = 1'b0;
        readyout_in    = 1'b0;
        resp_in        = 1'b0;

        step("rst_idle", 0, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("rst_live", 0, 1, HTRANS_NONSEQ, 32'hDEAD0000, HBURST_SINGLE, 1, 0, 1, 1, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'hDEAD0000, HBURST_SINGLE));
        step("post_rst", 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        step("grant_addr",  1, 1, HTRANS_NONSEQ, 32'h20000000, HBURST_SINGLE, 1, 1, 0, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h20000000, HBURST_SINGLE));
        step("grant_wait",  1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 0, 0, 0, 0, pack_exp(0, 0, 0, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("grant_done",  1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 1, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("grant_after", 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        step("blk_capture", 1, 1, HTRANS_NONSEQ, 32'h40000010, HBURST_SINGLE, 1, 0, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h40000010, HBURST_SINGLE));
        step("blk_held1",   1, 1, HTRANS_SEQ,    32'h55550000, HBURST_INCR,   0, 0, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h40000010, HBURST_SINGLE));
        step("blk_held2",   1, 1, HTRANS_SEQ,    32'h66660004, HBURST_INCR,   1, 0, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h40000010, HBURST_SINGLE));
        step("blk_held3",   1, 1, HTRANS_SEQ,    32'h66660004, HBURST_INCR,   0, 1, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h40000010, HBURST_SINGLE));
        step("blk_dwait",   1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 0, 0, 0, 0, pack_exp(0, 0, 0, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("blk_ddone",   1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 1, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        step("idle_sel",   1, 1, HTRANS_IDLE,   32'h00001000, HBURST_SINGLE, 1, 0, 0, 0, pack_exp(1, 0, 1, 0, HTRANS_IDLE,   32'h00001000, HBURST_SINGLE));
        step("busy_sel",   1, 1, HTRANS_BUSY,   32'h00001004, HBURST_INCR,   1, 0, 0, 0, pack_exp(1, 0, 1, 0, HTRANS_BUSY,   32'h00001004, HBURST_INCR));
        step("nosel_ns",   1, 0, HTRANS_NONSEQ, 32'h00009000, HBURST_SINGLE, 1, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_NONSEQ, 32'h00009000, HBURST_SINGLE));
        step("nordy_ns",   1, 1, HTRANS_NONSEQ, 32'h0000A000, HBURST_SINGLE, 0, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_NONSEQ, 32'h0000A000, HBURST_SINGLE));
        for (int i = 0; i < 8; i++) begin
            r_sel = 1'($urandom_range(0, 1));
            r_tr  = 2'($urandom_range(0, 1));
            r_ad  = $urandom;
            r_bu  = 3'($urandom_range(0, 7));
            step("rand_idlebusy", 1, r_sel, r_tr, r_ad, r_bu, 1, 0, 0, 0, pack_exp(r_sel, 0, 1, 0, r_tr, r_ad, r_bu));
        end
        step("no_hold", 1, 0, HTRANS_IDLE, 32'h0, HBURST_SINGLE, 1, 0, 0, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE, 32'h0, HBURST_SINGLE));

        step("err_addr",  1, 1, HTRANS_NONSEQ, 32'h30000000, HBURST_SINGLE, 1, 1, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h30000000, HBURST_SINGLE));
        step("err_cyc1",  1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 0, 0, 0, 1, pack_exp(0, 0, 0, 1, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("err_cyc2",  1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 1, 1, pack_exp(0, 0, 1, 1, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("err_after", 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 1, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        step("burst_b1",   1, 1, HTRANS_NONSEQ, 32'h00000100, HBURST_INCR4,  1, 0, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h00000100, HBURST_INCR4));
        step("burst_hld",  1, 1, HTRANS_SEQ,    32'h00000104, HBURST_INCR4,  0, 0, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h00000100, HBURST_INCR4));
        step("burst_gnt",  1, 1, HTRANS_SEQ,    32'h00000104, HBURST_INCR4,  0, 1, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h00000100, HBURST_INCR4));
        step("burst_b2",   1, 1, HTRANS_SEQ,    32'h00000104, HBURST_INCR4,  1, 1, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_SEQ,    32'h00000104, HBURST_INCR4));
        step("burst_b3",   1, 1, HTRANS_SEQ,    32'h00000108, HBURST_INCR4,  1, 1, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_SEQ,    32'h00000108, HBURST_INCR4));
        step("burst_b4",   1, 1, HTRANS_SEQ,    32'h0000010C, HBURST_INCR4,  1, 1, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_SEQ,    32'h0000010C, HBURST_INCR4));
        step("burst_end",  1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 1, 0, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        step("rh_capture", 1, 1, HTRANS_NONSEQ, 32'h70000000, HBURST_SINGLE, 1, 0, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h70000000, HBURST_SINGLE));
        step("rh_assert",  0, 1, HTRANS_SEQ,    32'h70000004, HBURST_SINGLE, 0, 0, 1, 0, pack_exp(1, 1, 0, 0, HTRANS_NONSEQ, 32'h70000000, HBURST_SINGLE));
        step("rh_cleared", 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 1, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("rd_grant",   1, 1, HTRANS_NONSEQ, 32'h80000000, HBURST_SINGLE, 1, 1, 1, 0, pack_exp(1, 0, 1, 0, HTRANS_NONSEQ, 32'h80000000, HBURST_SINGLE));
        step("rd_assert",  0, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 0, 0, 0, 1, pack_exp(0, 0, 0, 1, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));
        step("rd_cleared", 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE, 1, 0, 0, 1, pack_exp(0, 0, 1, 0, HTRANS_IDLE,   32'h0,        HBURST_SINGLE));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge HCLK);
        #5;
        check_eq("drain", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
